// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
// Multi-cycle WIDTH-bit adder that pushes the operands through one 4-bit
// ripple-carry slice, one nibble per clock, least significant nibble first.
// The slice carry is held in a register between nibbles. Valid/ready on
// both sides; all outputs are registered.
// WIDTH must be a multiple of 4 and at least 4.

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NIBBLES = WIDTH / 4;
    // Keep the index at least one bit wide so WIDTH=4 still elaborates.
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [WIDTH-1:0] sum_next;
    logic [IDX_W-1:0] idx_reg;
    logic             carry_reg;
    logic             cout_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic             busy_reg;

    logic [3:0]       slice_sum;
    logic             slice_co;
    logic             last_nibble;

    // The single 4-bit slice: the current nibble always sits in the low
    // four bits of the operand shift registers.
    assign {slice_co, slice_sum} = {1'b0, a_sh_reg[3:0]}
                                 + {1'b0, b_sh_reg[3:0]}
                                 + {4'd0, carry_reg};

    assign last_nibble = (idx_reg == IDX_W'(NIBBLES - 1));

    // Steer the slice result into the result nibble selected by idx; every
    // other nibble keeps its value.
    generate
        for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_sum_nib
            assign sum_next[4*gi +: 4] =
                (state_reg == RUN && idx_reg == IDX_W'(gi)) ? slice_sum
                                                            : sum_reg[4*gi +: 4];
        end
    endgenerate

    // Control FSM plus datapath registers; outputs are driven from registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            a_sh_reg      <= '0;
            b_sh_reg      <= '0;
            sum_reg       <= '0;
            idx_reg       <= '0;
            carry_reg     <= 1'b0;
            cout_reg      <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // in_ready_reg is high throughout IDLE
                    if (in_valid) begin
                        a_sh_reg     <= a;
                        b_sh_reg     <= b;
                        carry_reg    <= cin;
                        idx_reg      <= '0;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        state_reg    <= RUN;
                    end
                end
                RUN: begin
                    sum_reg   <= sum_next;
                    carry_reg <= slice_co;
                    a_sh_reg  <= a_sh_reg >> 4;
                    b_sh_reg  <= b_sh_reg >> 4;
                    idx_reg   <= idx_reg + 1'b1;
                    if (last_nibble) begin
                        cout_reg      <= slice_co;
                        idx_reg       <= '0;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    // Result held until taken; new work only from next cycle.
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign sum       = sum_reg;
    assign cout      = cout_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16).
// Expected results come from plain 17-bit addition of the operands.

module tb_nibble_serial_adder;

    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Advance one edge; sample/drive 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: full 17-bit sum.
    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    // Present one operation, then wait for out_valid (out_ready left to caller).
    // lat = cycle index of first out_valid minus cycle index of the accept.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                          output logic [W-1:0] rs, output logic rc, output int lat,
                          output bit ok);
        int n;
        int acc;
        ok = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        if (!in_ready) begin ok = 1'b0; rs = '0; rc = 1'b0; lat = -1; return; end
        a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
        acc = cyc;
        tick();
        in_valid = 1'b0;
        // scramble inputs after capture; must not influence the result
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        if (!out_valid) ok = 1'b0;
        rs = sum; rc = cout; lat = cyc - acc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (sum !== 16'h0000) begin failures++; $display("FAIL reset_sum: got %h expected 0000", sum); end
        checks++; if (cout !== 1'b0) begin failures++; $display("FAIL reset_cout: got %b expected 0", cout); end
    endtask

    task automatic test_directed();
        logic [W-1:0] va [3] = '{16'h1234, 16'hFFFF, 16'h8000};
        logic [W-1:0] vb [3] = '{16'h4321, 16'h0001, 16'h8000};
        logic         vc [3] = '{1'b0, 1'b0, 1'b1};
        logic [W-1:0] es [3] = '{16'h5555, 16'h0000, 16'h0001};
        logic         ec [3] = '{1'b0, 1'b1, 1'b1};
        logic [W-1:0] rs;
        logic         rc;
        int           lat;
        bit           ok;
        for (int i = 0; i < 3; i++) begin
            out_ready = 1'b0;
            run_op(va[i], vb[i], vc[i], rs, rc, lat, ok);
            $display("op a=%h b=%h cin=%b -> sum=%h cout=%b lat=%0d", va[i], vb[i], vc[i], rs, rc, lat);
            checks++; if (!ok) begin failures++; $display("FAIL directed_timeout[%0d]: got no result expected out_valid", i); end
            checks++; if (lat !== N + 1) begin failures++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, N + 1); end
            checks++; if (rs !== es[i]) begin failures++; $display("FAIL directed_sum[%0d]: got %h expected %h", i, rs, es[i]); end
            checks++; if (rc !== ec[i]) begin failures++; $display("FAIL directed_cout[%0d]: got %b expected %b", i, rc, ec[i]); end
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL directed_busy[%0d]: got %b expected 1", i, busy); end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL directed_handshake[%0d]: got out_valid=%b expected 0", i, out_valid); end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] ta = 16'hBEEF;
        logic [W-1:0] tb_v = 16'h1357;
        logic         tc = 1'b1;
        logic [W:0]   exp_v;
        logic [W-1:0] rs;
        logic         rc;
        int           lat;
        bit           ok;
        exp_v = ref_add(ta, tb_v, tc);
        out_ready = 1'b0;
        run_op(ta, tb_v, tc, rs, rc, lat, ok);
        checks++; if (!ok) begin failures++; $display("FAIL bp_timeout: got no result expected out_valid"); end
        // offer a second operation while the result is held
        a = 16'h0F0F; b = 16'h0101; cin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
                failures++; $display("FAIL bp_hold_ctrl[%0d]: got ov=%b ir=%b busy=%b expected 1 0 1", i, out_valid, in_ready, busy); end
            checks++; if ({cout, sum} !== exp_v) begin
                failures++; $display("FAIL bp_hold_data[%0d]: got %h expected %h", i, {cout, sum}, exp_v); end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        $display("op a=%h b=%h cin=%b -> released after backpressure", ta, tb_v, tc);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL bp_release: got ov=%b ir=%b expected 0 1", out_valid, in_ready); end
        checks++; if ({cout, sum} !== exp_v) begin
            failures++; $display("FAIL bp_keep_after: got %h expected %h", {cout, sum}, exp_v); end
        tick();
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL bp_no_second_accept: got busy=%b ov=%b expected 0 0", busy, out_valid); end
    endtask

    task automatic test_reset_abort();
        logic [W-1:0] rs;
        logic         rc;
        int           lat;
        bit           ok;
        out_ready = 1'b0;
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b0; in_valid = 1'b1;
        tick();                     // accept edge
        in_valid = 1'b0;
        tick();                     // now in second RUN cycle
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL abort_ctrl: got ir=%b ov=%b busy=%b expected 1 0 0", in_ready, out_valid, busy); end
        checks++; if (sum !== 16'h0000 || cout !== 1'b0) begin
            failures++; $display("FAIL abort_data: got sum=%h cout=%b expected 0000 0", sum, cout); end
        run_op(16'h00F0, 16'h0F10, 1'b0, rs, rc, lat, ok);
        $display("op a=00f0 b=0f10 cin=0 -> sum=%h cout=%b lat=%0d", rs, rc, lat);
        checks++; if (!ok || lat !== N + 1) begin failures++; $display("FAIL abort_next_latency: got %0d expected %0d", lat, N + 1); end
        checks++; if (rs !== 16'h1000 || rc !== 1'b0) begin
            failures++; $display("FAIL abort_next_result: got %h/%b expected 1000/0", rs, rc); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [W:0] exp_q [$];
        int         acc_q [$];
        int         issued = 0;
        int         got = 0;
        int         budget = 0;
        int         prev_acc = -1;
        bit         acc_now;
        logic [W:0] e;
        out_ready = 1'b1;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); in_valid = 1'b1;
        while (got < 20 && budget < 400) begin
            acc_now = in_valid && in_ready;
            if (out_valid) begin
                e = exp_q.pop_front();
                $display("op %0d -> sum=%h cout=%b", got, sum, cout);
                checks++; if ({cout, sum} !== e) begin
                    failures++; $display("FAIL b2b_result[%0d]: got %h expected %h", got, {cout, sum}, e); end
                got++;
            end
            if (acc_now) begin
                exp_q.push_back(ref_add(a, b, cin));
                if (prev_acc >= 0) begin
                    checks++; if (cyc - prev_acc !== N + 2) begin
                        failures++; $display("FAIL b2b_spacing[%0d]: got %0d expected %0d", issued, cyc - prev_acc, N + 2); end
                end
                prev_acc = cyc;
                acc_q.push_back(cyc);
                issued++;
            end
            tick();
            budget++;
            if (acc_now) begin
                if (issued < 20) begin
                    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        checks++; if (got !== 20) begin failures++; $display("FAIL b2b_count: got %0d expected 20", got); end
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
